// File: rtl/announce_pkg.sv
// Shared types and helpers for the colour-count announcement sequencer.
// Step order is also the order of the one-hot request vector (bit 0 = "red").
package announce_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DONE,
      ACK,
      GAP,
      FINISH
   } state_t;

   typedef enum logic [1:0] {
      STEP_RED,
      STEP_RED_CNT,
      STEP_GREEN,
      STEP_GREEN_CNT
   } step_t;

   localparam logic [3:0] TRACK_RED   = 4'd6;
   localparam logic [3:0] TRACK_GREEN = 4'd7;

   function automatic logic [3:0] clamp_count(input logic [3:0] cnt, input logic [3:0] lim);
      return (cnt > lim) ? lim : cnt;
   endfunction

   function automatic logic [3:0] step_onehot(input step_t s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// The count holds at zero instead of wrapping.
module seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/announce_sequencer.sv
// Drives audioSelect through "red", red count, "green", green count,
// handshaking each clip on the rising edge of sampleDone with a silence gap between.
module announce_sequencer
   import announce_pkg::*;
#(
   parameter int GAP_CYCLES     = 800000,
   parameter int TIMEOUT_CYCLES = 100000000,
   parameter int MAX_COUNT      = 5
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] redCountIn,
   input  logic [3:0] greenCountIn,
   input  logic       sampleDone,
   output logic [3:0] redCount,
   output logic [3:0] greenCount,
   output logic       redAudioRequest,
   output logic       redCountAudioRequest,
   output logic       greenAudioRequest,
   output logic       greenCountAudioRequest,
   output logic       sampleDoneAck,
   output logic       busy,
   output logic       done,
   output logic       timeoutErr
);

   localparam int TERM_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W    = $clog2(TERM_MAX) + 1;

   // Timers are loaded with N-1 so tc lands on the Nth cycle of the counted state.
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       COUNT_LIM = 4'(MAX_COUNT);

   state_t     state;
   step_t      step;
   logic       sd_q;
   logic       sd_rise;
   logic [3:0] req_q;
   logic       gap_tc;
   logic       tmo_tc;

   assign sd_rise = sampleDone & ~sd_q;

   seq_timer #(.W(CNT_W)) u_gap_timer (
      .clk      (CLOCK_50),
      .reset    (reset),
      .clr      (state == IDLE),
      .load     (state == ACK),
      .en       (state == GAP),
      .load_val (GAP_LOAD),
      .tc       (gap_tc)
   );

   seq_timer #(.W(CNT_W)) u_tmo_timer (
      .clk      (CLOCK_50),
      .reset    (reset),
      .clr      (state == IDLE),
      .load     (state == REQ),
      .en       (state == WAIT_DONE),
      .load_val (TMO_LOAD),
      .tc       (tmo_tc)
   );

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state         <= IDLE;
         step          <= STEP_RED;
         sd_q          <= 1'b0;
         req_q         <= '0;
         redCount      <= '0;
         greenCount    <= '0;
         sampleDoneAck <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         timeoutErr    <= 1'b0;
      end else begin
         sd_q          <= sampleDone;
         req_q         <= '0;
         sampleDoneAck <= 1'b0;
         done          <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  redCount   <= clamp_count(redCountIn, COUNT_LIM);
                  greenCount <= clamp_count(greenCountIn, COUNT_LIM);
                  step       <= STEP_RED;
                  timeoutErr <= 1'b0;
                  busy       <= 1'b1;
                  req_q      <= step_onehot(STEP_RED);
                  state      <= REQ;
               end
            end
            REQ: state <= WAIT_DONE;
            WAIT_DONE: begin
               // A real edge on the terminal cycle still counts as completion.
               if (sd_rise) begin
                  sampleDoneAck <= 1'b1;
                  state         <= ACK;
               end else if (tmo_tc) begin
                  timeoutErr    <= 1'b1;
                  sampleDoneAck <= 1'b1;
                  state         <= ACK;
               end
            end
            ACK: begin
               if (step == STEP_GREEN_CNT) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  step  <= step_t'(step + 2'd1);
                  state <= GAP;
               end
            end
            GAP: begin
               if (gap_tc) begin
                  req_q <= step_onehot(step);
                  state <= REQ;
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign redAudioRequest        = req_q[STEP_RED];
   assign redCountAudioRequest   = req_q[STEP_RED_CNT];
   assign greenAudioRequest      = req_q[STEP_GREEN];
   assign greenCountAudioRequest = req_q[STEP_GREEN_CNT];

endmodule

// File: tb/tb_announce_sequencer.sv
// Bench for announce_sequencer: a timeline model predicts every output per cycle
// from the handshake rules, and sampleDone is driven from that same predicted timeline.
module tb_announce_sequencer;

   localparam int GAPC = 4;
   localparam int TMO  = 50;
   localparam int MAXC = 5;
   localparam int MAXN = 512;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] redCountIn = '0;
   logic [3:0] greenCountIn = '0;
   logic       sampleDone = 1'b0;
   logic [3:0] redCount, greenCount;
   logic       redAudioRequest, redCountAudioRequest, greenAudioRequest, greenCountAudioRequest;
   logic       sampleDoneAck, busy, done, timeoutErr;

   announce_sequencer #(
      .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO), .MAX_COUNT(MAXC)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
      .redCountIn(redCountIn), .greenCountIn(greenCountIn), .sampleDone(sampleDone),
      .redCount(redCount), .greenCount(greenCount),
      .redAudioRequest(redAudioRequest), .redCountAudioRequest(redCountAudioRequest),
      .greenAudioRequest(greenAudioRequest), .greenCountAudioRequest(greenCountAudioRequest),
      .sampleDoneAck(sampleDoneAck), .busy(busy), .done(done), .timeoutErr(timeoutErr)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int failures = 0;

   // Expected per-cycle outputs and driven per-cycle inputs for one scenario.
   logic [3:0] e_req [MAXN];
   logic [3:0] e_rc  [MAXN];
   logic [3:0] e_gc  [MAXN];
   bit         e_ack [MAXN];
   bit         e_done[MAXN];
   bit         e_busy[MAXN];
   bit         e_terr[MAXN];
   bit         d_start[MAXN];
   bit         d_sd  [MAXN];
   bit         d_rst [MAXN];

   // Per-clip responder behaviour: 0 = rise dl cycles after request,
   // 1 = held high from before the request, falls at fl, rises at dl, 2 = never answers.
   int md[4];
   int dl[4];
   int fl[4];

   logic [3:0] cur_rc = '0;
   logic [3:0] cur_gc = '0;
   bit         cur_terr = 1'b0;

   task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp);
      end
   endtask

   task automatic set_all_normal(input int d);
      for (int k = 0; k < 4; k++) begin
         md[k] = 0; dl[k] = d; fl[k] = 0;
      end
   endtask

   task automatic run_scn(input logic [3:0] rin, input logic [3:0] gin,
                          input bit bstart, input bit rst_mid);
      int r, a, q, done_c, len, tfirst, rst_at, r1;
      logic [3:0] crc, cgc;
      for (int n = 0; n < MAXN; n++) begin
         e_req[n] = '0; e_ack[n] = 0; e_done[n] = 0; e_busy[n] = 0; e_terr[n] = 0;
         e_rc[n] = '0; e_gc[n] = '0; d_start[n] = 0; d_sd[n] = 0; d_rst[n] = 0;
      end
      crc = (rin > 4'(MAXC)) ? 4'(MAXC) : rin;
      cgc = (gin > 4'(MAXC)) ? 4'(MAXC) : gin;
      d_start[0] = 1;
      r = 1; a = 0; tfirst = -1; r1 = 0;
      for (int k = 0; k < 4; k++) begin
         e_req[r] = 4'(1 << k);
         if (k == 1) r1 = r;
         if (md[k] == 2) begin
            a = r + TMO + 1;
            if (tfirst < 0) tfirst = a;
         end else begin
            if (md[k] == 1) begin
               for (int n = a; n < r + fl[k]; n++) d_sd[n] = 1;
            end
            q = r + dl[k];
            a = q + 1;
            for (int n = q; n <= a; n++) d_sd[n] = 1;
         end
         e_ack[a] = 1;
         if (k < 3) r = a + GAPC + 1;
      end
      done_c = a + 1;
      e_done[done_c] = 1;
      len = done_c + 3;
      for (int n = 0; n < len; n++) begin
         e_busy[n] = (n >= 1) && (n <= done_c);
         e_rc[n]   = (n >= 1) ? crc : cur_rc;
         e_gc[n]   = (n >= 1) ? cgc : cur_gc;
         e_terr[n] = (n == 0) ? cur_terr : ((tfirst >= 0) && (n >= tfirst));
      end
      if (bstart) begin
         for (int i = 0; i < 4; i++) d_start[$urandom_range(1, done_c)] = 1;
      end
      if (rst_mid) begin
         rst_at = r1 + 3;
         d_rst[rst_at] = 1;
         for (int n = rst_at + 1; n < MAXN; n++) begin
            e_req[n] = '0; e_ack[n] = 0; e_done[n] = 0; e_busy[n] = 0; e_terr[n] = 0;
            e_rc[n] = '0; e_gc[n] = '0; d_start[n] = 0; d_sd[n] = 0;
         end
         len = rst_at + 4;
      end
      for (int n = 0; n < len; n++) begin
         @(posedge CLOCK_50);
         #1;
         reset        = d_rst[n];
         start        = d_start[n];
         sampleDone   = d_sd[n];
         redCountIn   = (n == 0) ? rin : 4'($urandom_range(0, 15));
         greenCountIn = (n == 0) ? gin : 4'($urandom_range(0, 15));
         @(negedge CLOCK_50);
         chk("requests", n, {4'b0, greenCountAudioRequest, greenAudioRequest,
                             redCountAudioRequest, redAudioRequest}, {4'b0, e_req[n]});
         chk("sampleDoneAck", n, {7'b0, sampleDoneAck}, {7'b0, e_ack[n]});
         chk("done", n, {7'b0, done}, {7'b0, e_done[n]});
         chk("busy", n, {7'b0, busy}, {7'b0, e_busy[n]});
         chk("timeoutErr", n, {7'b0, timeoutErr}, {7'b0, e_terr[n]});
         chk("redCount", n, {4'b0, redCount}, {4'b0, e_rc[n]});
         chk("greenCount", n, {4'b0, greenCount}, {4'b0, e_gc[n]});
      end
      cur_rc   = e_rc[len-1];
      cur_gc   = e_gc[len-1];
      cur_terr = e_terr[len-1];
   endtask

   initial begin
      int p;
      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("reset_outputs", 0, {busy, done, sampleDoneAck, timeoutErr, redAudioRequest,
                               redCountAudioRequest, greenAudioRequest, greenCountAudioRequest}, 8'h00);
      chk("reset_counts", 0, {redCount, greenCount}, 8'h00);
      @(posedge CLOCK_50);
      #1 reset = 1'b0;

      // Normal sequence, sampleDone 10 cycles after each request
      set_all_normal(10);
      run_scn(4'd2, 4'd3, 0, 0);

      // Clamp and latch
      set_all_normal(7);
      run_scn(4'd9, 4'd0, 0, 0);

      // Start re-asserted while busy
      set_all_normal(12);
      run_scn(4'd4, 4'd1, 1, 0);

      // Timeout on the "green" clip, then the next start clears the flag
      set_all_normal(10);
      md[2] = 2;
      run_scn(4'd5, 4'd6, 0, 0);
      set_all_normal(10);
      run_scn(4'd15, 4'd5, 0, 0);

      // Stale / held sampleDone across requests and gaps
      set_all_normal(10);
      md[0] = 1; fl[0] = 2; dl[0] = 6;
      md[1] = 1; fl[1] = 3; dl[1] = 8;
      md[2] = 1; fl[2] = 1; dl[2] = 2;
      run_scn(4'd1, 4'd2, 0, 0);

      // Edge on the timeout terminal cycle, and edge on the first wait cycle
      set_all_normal(10);
      dl[0] = TMO; dl[3] = 1;
      run_scn(4'd3, 4'd4, 0, 0);

      // Reset during the wait of step 1, then a clean restart
      set_all_normal(10);
      run_scn(4'd2, 4'd2, 0, 1);
      set_all_normal(5);
      run_scn(4'd3, 4'd1, 0, 0);

      // Randomized clips and counts
      for (int it = 0; it < 12; it++) begin
         for (int k = 0; k < 4; k++) begin
            p = $urandom_range(0, 9);
            if (p < 6) begin
               md[k] = 0; dl[k] = $urandom_range(1, TMO);
            end else if (p < 8) begin
               md[k] = 1; fl[k] = $urandom_range(1, 5); dl[k] = fl[k] + $urandom_range(1, 10);
            end else begin
               md[k] = 2;
            end
         end
         run_scn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/announce_sequencer.md
Name: announce_sequencer

Overview:
- Upstream controller for audioSelect. On a start pulse it captures the red and green object counts from the colour-recognition logic.
- It then issues four clip requests in a fixed order: "red" word, red count, "green" word, green count.
- Before the next request it waits for each clip's sampleDone, acknowledges it, and inserts a silence gap.
- This is the "keyboard controller" role that produces the request and acknowledge signals audioSelect consumes.

Parameters:
- GAP_CYCLES, 800000, silence between clips in CLOCK_50 cycles (16 ms). Must be ≥2.
- TIMEOUT_CYCLES, 100000000, maximum wait for sampleDone per clip (2 s).
- MAX_COUNT, 5, largest count with a clip; larger counts clamp to this value.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request announcement; level or pulse, sampled only in IDLE.
- redCountIn  in  4  live red object count.
- greenCountIn  in  4  live green object count.
- sampleDone  in  1  clip-finished flag from audioSelect.
- redCount  out  4  latched, clamped red count driven to audioSelect.
- greenCount  out  4  latched, clamped green count driven to audioSelect.
- redAudioRequest  out  1  one-cycle pulse: play "red".
- redCountAudioRequest  out  1  one-cycle pulse: play redCount digit.
- greenAudioRequest  out  1  one-cycle pulse: play "green".
- greenCountAudioRequest  out  1  one-cycle pulse: play greenCount digit.
- sampleDoneAck  out  1  one-cycle acknowledge of sampleDone.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when the sequence ends.
- timeoutErr  out  1  sticky; set on any clip timeout, cleared on the next accepted start.

Behaviour:
- Reset:
  - Takes effect on the clock edge, including mid-operation.
  - state=IDLE, step=0, counters=0.
  - All outputs are 0; redCount/greenCount are 0.
  - The sampleDone edge-detect register is 0.
- All outputs are registered. No combinational path from input to output.
- States:
  - IDLE → REQ → WAIT_DONE → ACK → GAP → REQ (next step) ...
  - After step 3 leaves ACK: → FINISH → IDLE.
- IDLE:
  - start=1 at edge t: redCount ← min(redCountIn, MAX_COUNT), greenCount ← min(greenCountIn, MAX_COUNT).
  - Same edge: step ← 0, timeoutErr ← 0, state ← REQ.
  - start is ignored in every other state.
- REQ (exactly 1 cycle):
  - Asserts the request selected by step: 0=redAudioRequest, 1=redCountAudioRequest, 2=greenAudioRequest, 3=greenCountAudioRequest.
  - Exactly one request is high, and only in this cycle.
  - → WAIT_DONE; timeout counter cleared.
- WAIT_DONE:
  - Acts only on a rising edge of sampleDone (sampleDone=1 and previous-cycle sampleDone=0).
  - The edge-detect register is updated every cycle.
  - A sampleDone that is already high on entry is ignored until it falls and rises again.
  - Rising edge → ACK.
  - Timeout counter reaching TIMEOUT_CYCLES-1 without an edge → timeoutErr ← 1, then → ACK (sequence continues).
  - A rising edge in the same cycle as the timeout terminal count counts as a normal completion; timeoutErr stays unchanged.
- ACK (1 cycle): sampleDoneAck=1. If step=3 → FINISH; else step ← step+1, gap counter cleared, → GAP.
- GAP: counts GAP_CYCLES cycles, then → REQ. sampleDone is ignored except for edge-register tracking.
- FINISH (1 cycle): done=1; → IDLE. busy drops in the following cycle.
- Latency:
  - Start edge to first request: 1 cycle.
  - sampleDone rising edge to sampleDoneAck: 1 cycle.
  - Ack to next request: GAP_CYCLES+1 cycles.
- Widths:
  - Counters are $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES))+1 bits, unsigned, no wrap (held at terminal).
  - Clamp compare is unsigned 4-bit.
- redCount/greenCount stay stable from latch until the next accepted start, so audioSelect's track lookup is valid during its request cycle.

Decomposition:
- Package announce_pkg:
  - state_t enum {IDLE, REQ, WAIT_DONE, ACK, GAP, FINISH}.
  - step_t 2-bit enum {STEP_RED, STEP_RED_CNT, STEP_GREEN, STEP_GREEN_CNT}.
  - Constant TRACK_RED=6, TRACK_GREEN=7.
- One sub-module, seq_timer:
  - Loadable down-counter with clear, enable, and terminal-count output.
  - Instantiated twice: gap timer and timeout timer.

Test Plan (bench overrides GAP_CYCLES=4, TIMEOUT_CYCLES=50, MAX_COUNT=5):
- Normal sequence:
  - Stimulus: redCountIn=2, greenCountIn=3, start pulse; bench model raises sampleDone 10 cycles after each request and holds it until ack.
  - Required: requests appear in order red, redCount, green, greenCount, each one cycle wide.
  - Required: redCount=2 and greenCount=3 throughout; 4 acks, each 1 cycle after a sampleDone rise; requests spaced by 4+1 cycles after each ack; done pulse; busy=0 after; timeoutErr=0.
- Clamp and latch:
  - Stimulus: redCountIn=9, greenCountIn=0 at start; redCountIn changes to 1 mid-sequence.
  - Required: redCount=5 and greenCount=0 throughout.
- Start while busy: start re-asserted during WAIT_DONE and GAP → ignored; the same four requests occur and exactly one done pulse.
- Timeout:
  - Stimulus: no sampleDone for the "green" clip.
  - Required: ack issued 50 cycles after entering WAIT_DONE; timeoutErr=1; sequence completes.
  - Required: the next start clears timeoutErr to 0.
- Stale/held sampleDone: sampleDone held high across a request and through the following GAP → no ack until it falls and rises; exactly one ack per rise.
- Reset mid-op: reset asserted for 1 cycle during WAIT_DONE of step 1 → next cycle all outputs 0, busy=0; a new start restarts from the red word request.
